// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
//
// Sequencer for the sine-table phase-accumulator counter. It fills the
// 2**ADDR_W x DATA_W sine table through SRAM write port 0 from a
// valid/ready source. It then enables read port 1 and walks the counter's
// tuning word `delta` from a start value to a stop value. Each tuning
// word is held for a fixed dwell.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   start        begin a sequence (only looked at while idle)
//   abort        return to idle on the next edge; beats every other input
//   skip_load    sampled with start: go straight to the sweep, keep table
//   loop         sampled at the end of each sweep: restart at delta_start
//   delta_start  first tuning word (sampled at start)
//   delta_stop   last tuning word (sampled at start)
//   dwell        cycles per tuning word (sampled at start, 0 acts as 1)
//   tbl_valid    table source word valid
//   tbl_data     table source word
//   tbl_ready    controller accepts a table word (high throughout LOAD)
//   csb0/web0    SRAM port-0 chip select / write enable, active-low
//   wmask0       SRAM port-0 byte write mask
//   addr0/din0   SRAM port-0 write address / data
//   csb1         SRAM port-1 (read) chip select, active-low
//   delta        tuning word to the phase accumulator
//   busy         controller is not idle
//   done         one-cycle pulse when a non-looping sweep finishes
module dds_sweep_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DELTA_W = 4,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               skip_load,
  input  logic               loop,
  input  logic [DELTA_W-1:0] delta_start,
  input  logic [DELTA_W-1:0] delta_stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               tbl_valid,
  input  logic [DATA_W-1:0]  tbl_data,
  output logic               tbl_ready,
  output logic               csb0,
  output logic               web0,
  output logic [3:0]         wmask0,
  output logic [ADDR_W-1:0]  addr0,
  output logic [DATA_W-1:0]  din0,
  output logic               csb1,
  output logic [DELTA_W-1:0] delta,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  wr_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  // Sweep configuration captured when a sequence is started.
  logic [DELTA_W-1:0] dstart_l;
  logic [DELTA_W-1:0] dstop_l;
  logic [DWELL_W-1:0] dwell_l;

  logic beat;
  logic accept_start;
  logic dwell_exp;
  logic at_stop;

  // One step of the tuning word toward the stop value. The current word
  // always lies between the start and stop values, so comparing it with
  // the stop value gives the sweep direction. When the two are equal the
  // word does not move, so the sweep never runs past the stop value.
  function automatic logic [DELTA_W-1:0] step_toward(
    input logic [DELTA_W-1:0] cur,
    input logic [DELTA_W-1:0] stop
  );
    if (cur < stop)
      step_toward = cur + DELTA_W'(1);
    else if (cur > stop)
      step_toward = cur - DELTA_W'(1);
    else
      step_toward = cur;
  endfunction

  // A dwell of 0 is treated as 1, so every tuning word is shown for at
  // least one cycle.
  function automatic logic [DWELL_W-1:0] dwell_clamp(
    input logic [DWELL_W-1:0] d
  );
    dwell_clamp = (d == '0) ? DWELL_W'(1) : d;
  endfunction

  assign tbl_ready    = (state == S_LOAD);
  assign beat         = tbl_valid & tbl_ready;
  assign accept_start = (state == S_IDLE) & start & ~abort;
  assign dwell_exp    = (dwell_cnt == dwell_l - DWELL_W'(1));
  assign at_stop      = (delta == dstop_l);

  // Configuration capture: plain data, loaded only when a start is taken.
  always_ff @(posedge clk) begin
    if (accept_start) begin
      dstart_l <= delta_start;
      dstop_l  <= delta_stop;
      dwell_l  <= dwell_clamp(dwell);
    end
  end

  // Sequencer state and registered SRAM/counter outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_cnt    <= '0;
      dwell_cnt <= '0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
      din0      <= '0;
      csb1      <= 1'b1;
      delta     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Drop any write in progress and park both ports. The tuning word
        // and the table contents are left as they are.
        state  <= S_IDLE;
        csb0   <= 1'b1;
        web0   <= 1'b1;
        wmask0 <= '0;
        csb1   <= 1'b1;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            csb0   <= 1'b1;
            web0   <= 1'b1;
            wmask0 <= '0;
            csb1   <= 1'b1;
            if (start) begin
              busy <= 1'b1;
              if (skip_load) begin
                // Jump straight into the sweep using the live inputs. The
                // captured copies become valid on this same edge.
                state     <= S_RUN;
                delta     <= delta_start;
                csb1      <= 1'b0;
                dwell_cnt <= '0;
              end else begin
                state  <= S_LOAD;
                wr_cnt <= '0;
              end
            end
          end

          S_LOAD: begin
            if (beat) begin
              csb0   <= 1'b0;
              web0   <= 1'b0;
              wmask0 <= 4'hF;
              addr0  <= wr_cnt;
              din0   <= tbl_data;
              wr_cnt <= wr_cnt + ADDR_W'(1);
              if (wr_cnt == LAST_ADDR)
                state <= S_SETTLE;
            end else begin
              csb0   <= 1'b1;
              web0   <= 1'b1;
              wmask0 <= '0;
            end
          end

          S_SETTLE: begin
            // The last table write is on the port during this cycle. The
            // read port is only enabled after that write has completed.
            csb0      <= 1'b1;
            web0      <= 1'b1;
            wmask0    <= '0;
            state     <= S_RUN;
            delta     <= dstart_l;
            csb1      <= 1'b0;
            dwell_cnt <= '0;
          end

          S_RUN: begin
            if (!dwell_exp) begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end else if (!at_stop) begin
              delta     <= step_toward(delta, dstop_l);
              dwell_cnt <= '0;
            end else if (loop) begin
              delta     <= dstart_l;
              dwell_cnt <= '0;
            end else begin
              // The sweep has ended: delta keeps showing the stop value.
              state <= S_IDLE;
              csb1  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
